sram_port_arbiter: RTL and testbench

Sequences the single external 16-bit SRAM and shares it between two requesters: port 0 (CPU MAR/MDR path) and port 1 (program loader / debug port). Converts a level req/ack handshake into correctly timed active-low SRAM strobes with a configurable number of access wait cycles. It sits between the requesters and the Mem2IO/tristate path, owning CE, UB, LB, OE and WE.

---
 rtl/sram_port_arbiter_if.sv | 17 +
 rtl/sram_port_arbiter.sv | 101 ++++++++++
 tb/tb_sram_port_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: requester req/ack handshake plus SRAM strobe/address/data pins.
// slave is the arbiter's view; master is the requester/memory side.
interface sram_port_arbiter_if;
  logic        req0, req1, we0, we1, ack0, ack1, busy, owner;
  logic [15:0] addr0, addr1, wdata0, wdata1, rdata;
  logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
  logic [19:0] ADDR;
  logic [15:0] Data_to_SRAM, Data_from_SRAM;
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, Data_from_SRAM,
    output ack0, ack1, rdata, busy, owner, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, ADDR, Data_to_SRAM
  );
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, Data_from_SRAM,
    input  ack0, ack1, rdata, busy, owner, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, ADDR, Data_to_SRAM
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one 16-bit async SRAM between two req/ack ports with registered strobes.
// Define SRAM_ARB_RR_EN for round-robin on simultaneous requests; otherwise port 0 has fixed priority.
module sram_port_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input logic Clk,
  input logic Reset,
  sram_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES must be in 1..15");
  end

  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic        r_we, r_owner, r_busy, r_ack0, r_ack1;
  logic        r_ce_n, r_oe_n, r_we_n;
  logic [15:0] r_addr, r_wdata, r_rdata;
  logic        w_grant, w_gnt, w_we;
  logic        w_ce, w_oe, w_wr, w_ack0, w_ack1;

  assign w_grant = (r_state == IDLE) & (bus.req0 | bus.req1);

`ifdef SRAM_ARB_RR_EN
  // r_prio names the port that wins the next tie; it flips away from every grant
  logic r_prio;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) r_prio <= 1'b0;
    else if (w_grant) r_prio <= ~w_gnt;
  assign w_gnt = (bus.req0 & bus.req1) ? r_prio : bus.req1;
`else
  assign w_gnt = bus.req1 & ~bus.req0;
`endif

  // the grant cycle must already see the requester's direction to drive OE in SETUP
  assign w_we = (r_state == IDLE) ? (w_gnt ? bus.we1 : bus.we0) : r_we;

  always_comb begin
    w_next = (r_state == IDLE)   ? ((bus.req0 | bus.req1) ? SETUP : IDLE) :
             (r_state == SETUP)  ? ACCESS :
             (r_state == ACCESS) ? ((r_cnt == 4'd0) ? DONE : ACCESS) : IDLE;
  end

  always_comb begin
    w_ce   = w_next != IDLE;
    w_oe   = ~w_we & ((w_next == SETUP) | (w_next == ACCESS));
    w_wr   = w_we & (w_next == ACCESS);
    w_ack0 = (w_next == DONE) & ~r_owner;
    w_ack1 = (w_next == DONE) & r_owner;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_owner <= 1'b0;
      r_busy  <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_addr  <= 16'h0000;
      r_wdata <= 16'h0000;
      r_rdata <= 16'h0000;
    end else begin
      r_state <= w_next;
      r_busy  <= w_next != IDLE;
      r_ack0  <= w_ack0;
      r_ack1  <= w_ack1;
      r_ce_n  <= ~w_ce;
      r_oe_n  <= ~w_oe;
      r_we_n  <= ~w_wr;
      r_cnt   <= (r_state == SETUP) ? 4'(WAIT_CYCLES - 1) :
                 ((r_state == ACCESS) && (r_cnt != 4'd0)) ? r_cnt - 4'd1 : r_cnt;
      if (w_grant) begin
        r_owner <= w_gnt;
        r_we    <= w_we;
        r_addr  <= w_gnt ? bus.addr1 : bus.addr0;
        r_wdata <= w_gnt ? bus.wdata1 : bus.wdata0;
      end
      if ((r_state == ACCESS) && (r_cnt == 4'd0) && !r_we) r_rdata <= bus.Data_from_SRAM;
    end
  end

  assign bus.Mem_CE       = r_ce_n;
  assign bus.Mem_UB       = r_ce_n;
  assign bus.Mem_LB       = r_ce_n;
  assign bus.Mem_OE       = r_oe_n;
  assign bus.Mem_WE       = r_we_n;
  assign bus.ADDR         = {4'b0000, r_addr};
  assign bus.Data_to_SRAM = r_wdata;
  assign bus.ack0         = r_ack0;
  assign bus.ack1         = r_ack1;
  assign bus.rdata        = r_rdata;
  assign bus.busy         = r_busy;
  assign bus.owner        = r_owner;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed plus randomized checks of sram_port_arbiter against a transaction-level model.
// Build with or without SRAM_ARB_RR_EN; the grant model follows the same macro.
module tb_sram_port_arbiter;
  localparam int W = 2;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  sram_port_arbiter_if bus();
  sram_port_arbiter #(.WAIT_CYCLES(W)) u_dut (.Clk(Clk), .Reset(Reset), .bus(bus.slave));

  int checks = 0, errors = 0;
  int cyc = 0, we_lo = 0, oe_lo = 0, ack0_n = 0, ack1_n = 0, prot_err = 0;
  int prefer = 0;
  bit prev_ce = 1'b0;
  logic [15:0] ref_mem [logic [15:0]];

  // SRAM model: unwritten words return a fixed pattern of their address
  logic [15:0] sram [0:65535];
  bit          vld  [0:65535];
  function automatic logic [15:0] init_val(logic [15:0] a);
    return (a == 16'h1234) ? 16'h5A5A : {a[7:0], ~a[7:0]};
  endfunction
  always @(posedge Clk)
    if (Reset && !bus.Mem_CE && !bus.Mem_WE) begin
      sram[bus.ADDR[15:0]] <= bus.Data_to_SRAM;
      vld[bus.ADDR[15:0]]  <= 1'b1;
    end
  always @(negedge Clk)
    bus.Data_from_SRAM <= vld[bus.ADDR[15:0]] ? sram[bus.ADDR[15:0]] : init_val(bus.ADDR[15:0]);

  always @(posedge Clk) cyc <= cyc + 1;
  always @(negedge Clk) begin
    if (Reset) begin
      if (!bus.Mem_WE) we_lo <= we_lo + 1;
      if (!bus.Mem_OE && prev_ce) oe_lo <= oe_lo + 1;
      if (bus.ack0) ack0_n <= ack0_n + 1;
      if (bus.ack1) ack1_n <= ack1_n + 1;
      if ((!bus.Mem_OE && !bus.Mem_WE) || (!bus.Mem_WE && !prev_ce)) prot_err <= prot_err + 1;
    end
    prev_ce <= !bus.Mem_CE;
  end

  logic [1:0] xreq = 2'b00;
  for (genvar g = 0; g < 2; g++) begin : g_x
    sram_port_arbiter_if x();
    sram_port_arbiter #(.WAIT_CYCLES(g == 0 ? 1 : 15)) u_dut (.Clk(Clk), .Reset(Reset), .bus(x.slave));
    assign x.req0 = xreq[g];
    assign x.req1 = 1'b0;
    assign x.we0 = 1'b0;
    assign x.we1 = 1'b0;
    assign x.addr0 = 16'h0042;
    assign x.addr1 = 16'h0000;
    assign x.wdata0 = 16'h0000;
    assign x.wdata1 = 16'h0000;
    assign x.Data_from_SRAM = 16'h1357;
    int oe_n = 0;
    bit pce = 1'b0;
    always @(negedge Clk) begin
      if (!x.Mem_OE && pce) oe_n <= oe_n + 1;
      pce <= !x.Mem_CE;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(bit r0, bit r1);
`ifdef SRAM_ARB_RR_EN
    return (r0 && r1) ? prefer : int'(r1);
`else
    return (r1 && !r0) ? 1 : 0;
`endif
  endfunction

  function automatic logic [15:0] ref_rd(logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(posedge Clk); #1;
      ok = bus.ack0 | bus.ack1;
    end
    chk("ack_seen", ok, 1);
  endtask

  task automatic run_txn(input bit r0, input bit r1, input bit w0, input bit w1,
                         input logic [15:0] a0, input logic [15:0] a1,
                         input logic [15:0] d0, input logic [15:0] d1);
    bit p0, p1, ok, w;
    int g, t0, lat_exp, b0, b1;
    logic [15:0] a, d;
    @(negedge Clk);
    bus.we0 = w0; bus.we1 = w1; bus.addr0 = a0; bus.addr1 = a1;
    bus.wdata0 = d0; bus.wdata1 = d1; bus.req0 = r0; bus.req1 = r1;
    p0 = r0; p1 = r1; t0 = cyc; lat_exp = W + 2;
    while (p0 || p1) begin
      g = model_grant(p0, p1);
      prefer = 1 - g;
      a = g ? a1 : a0; d = g ? d1 : d0; w = g ? w1 : w0;
      we_lo = 0; oe_lo = 0; b0 = ack0_n; b1 = ack1_n;
      wait_ack(ok);
      chk("ack0", bus.ack0, g == 0);
      chk("ack1", bus.ack1, g == 1);
      chk("latency", cyc - t0, lat_exp);
      chk("owner", bus.owner, g);
      chk("addr", bus.ADDR, {4'b0000, a});
      if (w) ref_mem[a] = d;
      else chk("rdata", bus.rdata, ref_rd(a));
      chk("we_low_cycles", we_lo, w ? W : 0);
      chk("oe_low_cycles", oe_lo, w ? 0 : W);
      if (g == 1) begin bus.req1 = 1'b0; p1 = 1'b0; end
      else begin bus.req0 = 1'b0; p0 = 1'b0; end
      t0 = cyc; lat_exp = W + 3;
      @(posedge Clk); #1;
      chk("ack_pulse", {bus.ack0, bus.ack1}, 0);
      chk("ack_count", (ack0_n - b0) + (ack1_n - b1), 1);
      chk("busy_idle", bus.busy, 0);
    end
  endtask

  initial begin
    bit ok;
    int g, b0, t0, l0, l1;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
    repeat (3) @(negedge Clk);
    chk("rst_strobes", {bus.Mem_CE, bus.Mem_UB, bus.Mem_LB, bus.Mem_OE, bus.Mem_WE}, 5'h1F);
    chk("rst_addr", bus.ADDR, 0);
    chk("rst_wdata", bus.Data_to_SRAM, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_ack", {bus.ack0, bus.ack1}, 0);
    chk("rst_busy_owner", {bus.busy, bus.owner}, 0);
    Reset = 1'b1;

    run_txn(1, 0, 1, 0, 16'h0042, 16'h0000, 16'hBEEF, 16'h0000);
    run_txn(1, 0, 0, 0, 16'h0042, 16'h0000, 16'h0000, 16'h0000);
    chk("read_beef", bus.rdata, 16'hBEEF);
    b0 = ack0_n;
    run_txn(0, 1, 0, 0, 16'h0000, 16'h1234, 16'h0000, 16'h0000);
    chk("p1_no_ack0", ack0_n, b0);
    chk("p1_rdata", bus.rdata, 16'h5A5A);

    // both ports held continuously, then port 0 withdraws
    @(negedge Clk);
    bus.we0 = 0; bus.we1 = 0; bus.addr0 = 16'h0042; bus.addr1 = 16'h1234;
    bus.req0 = 1; bus.req1 = 1;
    for (int k = 0; k < 5; k++) begin
      g = model_grant(bus.req0, bus.req1);
      prefer = 1 - g;
      wait_ack(ok);
      chk("cont_ack0", bus.ack0, g == 0);
      chk("cont_ack1", bus.ack1, g == 1);
      chk("cont_rdata", bus.rdata, ref_rd(g ? 16'h1234 : 16'h0042));
      if (k == 3) bus.req0 = 0;
      if (k == 4) bus.req1 = 0;
    end
    @(posedge Clk); #1;

    // reset while a write is in its access phase
    @(negedge Clk);
    bus.we0 = 1; bus.addr0 = 16'h0099; bus.wdata0 = 16'h1111; bus.req0 = 1;
    b0 = ack0_n;
    @(posedge Clk); @(posedge Clk); #2;
    chk("midrst_we_low", bus.Mem_WE, 0);
    chk("midrst_busy", bus.busy, 1);
    Reset = 1'b0;
    #1;
    chk("midrst_strobes", {bus.Mem_CE, bus.Mem_OE, bus.Mem_WE}, 3'b111);
    chk("midrst_ack_busy", {bus.ack0, bus.ack1, bus.busy}, 0);
    @(negedge Clk);
    bus.req0 = 0;
    @(negedge Clk);
    Reset = 1'b1;
    prefer = 0;
    chk("midrst_rdata", bus.rdata, 0);
    repeat (2) @(negedge Clk);
    chk("midrst_no_ack", ack0_n, b0);
    run_txn(1, 0, 0, 0, 16'h0042, 16'h0000, 16'h0000, 16'h0000);
    chk("post_rst_read", bus.rdata, 16'hBEEF);

    repeat (16) begin
      bit r0, r1;
      r0 = 1'($urandom); r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      run_txn(r0, r1, 1'($urandom), 1'($urandom),
              16'h0100 + 16'($urandom_range(0, 7)), 16'h0100 + 16'($urandom_range(0, 7)),
              16'($urandom), 16'($urandom));
    end
    chk("protocol", prot_err, 0);

    // WAIT_CYCLES = 1 and 15 instances, both read together
    @(negedge Clk);
    xreq = 2'b11; t0 = cyc; l0 = 0; l1 = 0;
    for (int i = 0; i < 40 && (l0 == 0 || l1 == 0); i++) begin
      @(posedge Clk); #1;
      if (g_x[0].x.ack0 && l0 == 0) begin l0 = cyc - t0; xreq[0] = 1'b0; chk("w1_rdata", g_x[0].x.rdata, 16'h1357); end
      if (g_x[1].x.ack0 && l1 == 0) begin l1 = cyc - t0; xreq[1] = 1'b0; chk("w15_rdata", g_x[1].x.rdata, 16'h1357); end
    end
    chk("w1_latency", l0, 3);
    chk("w15_latency", l1, 17);
    @(negedge Clk);
    chk("w1_oe_cycles", g_x[0].oe_n, 1);
    chk("w15_oe_cycles", g_x[1].oe_n, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule
